// File: rtl/div_32bit_seq_pkg.sv
// div_32bit_seq_pkg: shared state encoding and constants for the sequential divider
package div_32bit_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} div_state_t;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER = 32;
    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_32bit_seq_if.sv
// div_32bit_seq_if: start/busy/done handshake and operand/result bus of the divider
interface div_32bit_seq_if;
    import div_32bit_seq_pkg::*;
    logic start;
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic busy;
    logic done;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic div_by_zero;
    modport master(output start, dividend, divisor, input busy, done, quotient, remainder, div_by_zero);
    modport slave(input start, dividend, divisor, output busy, done, quotient, remainder, div_by_zero);
endinterface

// File: rtl/CSA_32bit.sv
// CSA_32bit: 32-bit carry-select adder built from eight 4-bit blocks
module CSA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [8:0] c;
    assign c[0] = cin;
    for (genvar g = 0; g < 8; g++) begin : blk
        logic [4:0] s0, s1;
        assign s0 = {1'b0, a[4*g+:4]} + {1'b0, b[4*g+:4]};
        assign s1 = {1'b0, a[4*g+:4]} + {1'b0, b[4*g+:4]} + 5'd1;
        assign sum[4*g+:4] = c[g] ? s1[3:0] : s0[3:0];
        assign c[g+1] = c[g] ? s1[4] : s0[4];
    end
    assign cout = c[8];
endmodule

// File: rtl/div_32bit_seq.sv
// div_32bit_seq: unsigned restoring divider, one quotient bit per clock via CSA_32bit subtract
module div_32bit_seq
    import div_32bit_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    div_32bit_seq_if.slave bus
);
    div_state_t state;
    logic [WIDTH-1:0] r, q, d, diff, r_nx, q_nx, quotient, remainder;
    logic [WIDTH:0] rs;
    logic [4:0] count;
    logic c, ge, busy, done, div_by_zero;
    assign rs = {r, q[WIDTH-1]};
    CSA_32bit u_sub (.a(rs[WIDTH-1:0]), .b(~d), .cin(1'b1), .sum(diff), .cout(c));
    assign ge = rs[WIDTH] | c;
    assign r_nx = ge ? diff : rs[WIDTH-1:0];
    assign q_nx = {q[WIDTH-2:0], ge};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            r <= '0;
            q <= '0;
            d <= '0;
            count <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    d <= bus.divisor;
                    q <= bus.dividend;
                    r <= '0;
                    count <= '0;
                    if (bus.divisor == '0) begin
                        state <= DONE;
                        done <= 1'b1;
                        quotient <= DBZ_QUOTIENT;
                        remainder <= bus.dividend;
                        div_by_zero <= 1'b1;
                    end else begin
                        state <= CALC;
                        busy <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    r <= r_nx;
                    q <= q_nx;
                    count <= count + 5'd1;
                    if (count == 5'(DIV_ITER - 1)) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        quotient <= q_nx;
                        remainder <= r_nx;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.quotient = quotient;
    assign bus.remainder = remainder;
    assign bus.div_by_zero = div_by_zero;
endmodule

// File: doc/div_32bit_seq.md
Name: div_32bit_seq

Overview:
Sequential unsigned 32-bit restoring divider, the inverse-operation companion to the team's 32-bit carry-select adder.
- Produces one quotient bit per clock by trial subtraction; the subtraction runs through the existing CSA_32bit adder (B inverted, Cin=1).
- Sits beside the adder/multiplier datapath.
- Uses a start/busy/done handshake toward a controlling block or testbench.

Parameters:
WIDTH, 32, operand width; only 32 is supported because it matches the fixed-width CSA_32bit.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
dividend  input  32  numerator, captured on accepted start
divisor  input  32  denominator, captured on accepted start
busy  output  1  high while an operation is in progress (CALC)
done  output  1  one-cycle pulse when results become valid
quotient  output  32  result quotient, held until next accepted start
remainder  output  32  result remainder, held until next accepted start
div_by_zero  output  1  high with done when the captured divisor==0; held with results

Behaviour:
Interface rule (already decided):
- One clock (clk); reset rst_n is asynchronous and active-low.

Reset:
- rst_n low → state IDLE.
- busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Internal registers (R, Q, D, count) cleared.
- Reset asserted mid-operation aborts the operation immediately; no done pulse is produced.

States:
- IDLE:
  - start=1 → capture D=divisor, Q=dividend, R=0, count=0, clear div_by_zero.
  - If divisor==0 → DONE. Otherwise → CALC.
- CALC (busy=1), each cycle:
  - Rs = {R[31:0], Q[31]} (33 bits).
  - Trial = Rs[31:0] + ~D + 1 via CSA_32bit, with carry c.
  - Trial is non-negative iff Rs[32]==1 or c==1.
  - If non-negative: R ← trial (33-bit, upper bit 0) and Q ← {Q[30:0],1}. Else: R ← Rs and Q ← {Q[30:0],0}.
  - count increments; after the 32nd iteration (count==31) → DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient/remainder registered from Q/R[31:0].
  - Divide by zero: quotient=32'hFFFF_FFFF, remainder=dividend, div_by_zero=1.
  - Next state IDLE unconditionally; start during DONE is ignored.

Latency:
- Start accepted at edge T0.
- busy high for cycles T1..T32.
- done pulses in cycle T33; results visible in that cycle.
- Divide-by-zero: done in cycle T1, busy never asserts.

Other rules:
- start while busy or done is ignored; operands are not re-captured.
- Back-to-back: start may be asserted in the cycle after done (IDLE); the next done follows 33 cycles later.
- Outputs are stable between done pulses; operand inputs may change freely after acceptance.
- Arithmetic is unsigned. Remainder is always < divisor (divisor≠0). quotient×divisor+remainder == dividend, modulo 2^32 not required because it is exact.

Decomposition:
- Shared package holds:
  - state encoding IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - DIV_WIDTH=32;
  - DIV_ITER=32;
  - divide-by-zero quotient constant 32'hFFFF_FFFF.
- One sub-module instance: the existing CSA_32bit as the trial subtractor (A=Rs[31:0], B=~D, Cin=1'b1).
- The remaining logic is a single FSM plus shift registers; no further sub-modules.

Test Plan:
1. rst_n low then high; dividend=100, divisor=7, start one cycle → done exactly 33 cycles after start edge; quotient=14, remainder=2, div_by_zero=0, busy high for 32 cycles.
2. dividend=32'hFFFF_FFFF, divisor=1 → quotient=32'hFFFF_FFFF, remainder=0. Then dividend=32'hFFFF_FFFF, divisor=32'hFFFF_FFFF → quotient=1, remainder=0.
3. dividend=3, divisor=10 → quotient=0, remainder=3. Then dividend=5, divisor=0 → done on the cycle after start, busy never 1, quotient=32'hFFFF_FFFF, remainder=5, div_by_zero=1.
4. Start 1000/3; re-pulse start with 50/5 at cycle 10 → ignored; result quotient=333, remainder=1; next start immediately after done with 50/5 → quotient=10, remainder=0.
5. Start 12345/67; drop rst_n at cycle 15 → all outputs 0 asynchronously, no done; after release, 12345/67 → quotient=184, remainder=17.
6. 10,000 random operand pairs (divisor≠0), back-to-back → quotient/remainder match the reference model (/ and %), done count equals start count.
